// File: rtl/spi_proto_pkg.sv
// Shared state encoding and command opcodes for the SPI protocol decoder.
package spi_proto_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_REG_ADDR,
    ST_REG_WR,
    ST_REG_RD,
    ST_FB_AH,
    ST_FB_AL,
    ST_FB_DATA,
    ST_DISCARD
  } state_t;

  localparam logic [7:0] CMD_REG_WR = 8'h01;
  localparam logic [7:0] CMD_REG_RD = 8'h02;
  localparam logic [7:0] CMD_SWAP   = 8'h04;
  localparam logic [7:0] CMD_FB_WR  = 8'h80;

endpackage

// File: rtl/spi_proto_decoder.sv
// SPI command decoder: turns one CS_n-low transaction into register-bus
// accesses, 16-bit framebuffer writes or a buffer-swap request, and feeds
// the next MISO byte back to the SPI core. FB_AW must be greater than 8.
module spi_proto_decoder
  import spi_proto_pkg::*;
#(
  parameter int         FB_AW   = 13,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_stb,
  output logic [7:0]       tx_data,
  input  logic             tx_ack,
  input  logic             csn_rise,
  input  logic             csn_fall,
  output logic [7:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic [FB_AW-1:0] fb_waddr,
  output logic [15:0]      fb_wdata,
  output logic             fb_we,
  output logic             frame_swap
);

  localparam logic [FB_AW-1:0] FB_ONE = {{(FB_AW-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_wr_flag;
  logic             r_half;
  logic [7:0]       r_hi;
  logic             r_swap_pend;
  logic             r_rd_cap;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_reg_addr;
  logic [7:0]       r_reg_wdata;
  logic             r_reg_we;
  logic             r_reg_re;
  logic [FB_AW-1:0] r_fb_waddr;
  logic [15:0]      r_fb_wdata;
  logic             r_fb_we;
  logic             r_frame_swap;

  logic             w_byte;
  logic             w_in_txn;
  logic             w_swap_now;

  // A start-of-transaction pulse overrides any byte arriving in the same cycle.
  assign w_byte     = rx_stb && !csn_fall;
  // Read-pipeline activity only counts while the transaction is still open.
  assign w_in_txn   = !csn_rise && !csn_fall;
  // A swap command coincident with CS_n rising must still request the swap.
  assign w_swap_now = r_swap_pend ||
                      (w_byte && (r_state == ST_CMD) && (rx_data == CMD_SWAP));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: CS_n edges dominate, otherwise advance per received byte.
  always_comb begin
    w_state_nxt = r_state;
    if (csn_fall) begin
      w_state_nxt = ST_CMD;
    end else if (csn_rise) begin
      w_state_nxt = ST_IDLE;
    end else if (rx_stb) begin
      case (r_state)
        ST_CMD: begin
          case (rx_data)
            CMD_REG_WR, CMD_REG_RD: w_state_nxt = ST_REG_ADDR;
            CMD_FB_WR:              w_state_nxt = ST_FB_AH;
            default:                w_state_nxt = ST_DISCARD;
          endcase
        end
        ST_REG_ADDR: w_state_nxt = r_wr_flag ? ST_REG_WR : ST_REG_RD;
        ST_FB_AH:    w_state_nxt = ST_FB_AL;
        ST_FB_AL:    w_state_nxt = ST_FB_DATA;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath: byte capture, bus strobes, address auto-increment and MISO data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_flag    <= 1'b0;
      r_half       <= 1'b0;
      r_hi         <= 8'h00;
      r_swap_pend  <= 1'b0;
      r_rd_cap     <= 1'b0;
      r_tx_data    <= ID_BYTE;
      r_reg_addr   <= 8'h00;
      r_reg_wdata  <= 8'h00;
      r_reg_we     <= 1'b0;
      r_reg_re     <= 1'b0;
      r_fb_waddr   <= '0;
      r_fb_wdata   <= 16'h0000;
      r_fb_we      <= 1'b0;
      r_frame_swap <= 1'b0;
    end else begin
      r_reg_we     <= 1'b0;
      r_reg_re     <= 1'b0;
      r_fb_we      <= 1'b0;
      r_frame_swap <= 1'b0;
      // reg_rdata is valid the cycle after reg_re; this flag marks that cycle.
      r_rd_cap     <= r_reg_re;

      // Addresses advance the cycle after each write strobe.
      if (r_reg_we) r_reg_addr <= r_reg_addr + 8'd1;
      if (r_fb_we)  r_fb_waddr <= r_fb_waddr + FB_ONE;

      // Late read data from a closed transaction must not reach MISO.
      if (r_rd_cap && (r_state == ST_REG_RD) && w_in_txn) r_tx_data <= reg_rdata;

      if (w_byte) begin
        case (r_state)
          ST_CMD: begin
            r_wr_flag <= (rx_data == CMD_REG_WR);
            if (rx_data == CMD_SWAP) r_swap_pend <= 1'b1;
          end
          ST_REG_ADDR: begin
            r_reg_addr <= rx_data;
            if (!r_wr_flag) r_reg_re <= 1'b1;
          end
          ST_REG_WR: begin
            r_reg_wdata <= rx_data;
            r_reg_we    <= 1'b1;
          end
          ST_FB_AH: r_fb_waddr[FB_AW-1:8] <= rx_data[FB_AW-9:0];
          ST_FB_AL: r_fb_waddr[7:0]       <= rx_data;
          ST_FB_DATA: begin
            if (!r_half) begin
              r_hi   <= rx_data;
              r_half <= 1'b1;
            end else begin
              r_fb_wdata <= {r_hi, rx_data};
              r_fb_we    <= 1'b1;
              r_half     <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // Each consumed MISO byte in a read fetches the following register.
      if (tx_ack && (r_state == ST_REG_RD) && w_in_txn) begin
        r_reg_addr <= r_reg_addr + 8'd1;
        r_reg_re   <= 1'b1;
      end

      if (csn_rise) begin
        r_half       <= 1'b0;
        r_swap_pend  <= 1'b0;
        r_tx_data    <= ID_BYTE;
        r_frame_swap <= w_swap_now;
      end

      if (csn_fall) begin
        r_half      <= 1'b0;
        r_swap_pend <= 1'b0;
        r_tx_data   <= ID_BYTE;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign reg_addr   = r_reg_addr;
  assign reg_wdata  = r_reg_wdata;
  assign reg_we     = r_reg_we;
  assign reg_re     = r_reg_re;
  assign fb_waddr   = r_fb_waddr;
  assign fb_wdata   = r_fb_wdata;
  assign fb_we      = r_fb_we;
  assign frame_swap = r_frame_swap;

endmodule

// File: tb/tb_spi_proto_decoder.sv
// Testbench for spi_proto_decoder: a behavioural SPI-core driver, a register
// file model, bus monitors and a transaction-level reference model.
module tb_spi_proto_decoder;

  localparam int         FB_AW = 13;
  localparam logic [7:0] ID    = 8'hA5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_stb = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_ack = 1'b0;
  logic             csn_rise = 1'b0;
  logic             csn_fall = 1'b0;
  logic [7:0]       reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic             reg_re;
  logic [7:0]       reg_rdata;
  logic [FB_AW-1:0] fb_waddr;
  logic [15:0]      fb_wdata;
  logic             fb_we;
  logic             frame_swap;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_proto_decoder #(.FB_AW(FB_AW), .ID_BYTE(ID)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_stb(rx_stb),
    .tx_data(tx_data), .tx_ack(tx_ack), .csn_rise(csn_rise), .csn_fall(csn_fall),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .frame_swap(frame_swap)
  );

  // Register file: read data appears the cycle after reg_re.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (rst)         reg_rdata <= 8'h00;
    else if (reg_re) reg_rdata <= mem[reg_addr];
  end

  // Bus monitors, sampled mid-cycle.
  logic [15:0] act_wr[$];
  logic [7:0]  act_re[$];
  logic [28:0] act_fb[$];
  logic [7:0]  act_miso[$];
  int          swap_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_we)     act_wr.push_back({reg_addr, reg_wdata});
      if (reg_re)     act_re.push_back(reg_addr);
      if (fb_we)      act_fb.push_back({fb_waddr, fb_wdata});
      if (tx_ack)     act_miso.push_back(tx_data);
      if (frame_swap) swap_cnt++;
    end
  end

  // Expected results of one transaction.
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_re[$];
  logic [28:0] exp_fb[$];
  logic [7:0]  exp_miso[$];
  int          exp_swap;

  int b_wr, b_re, b_fb, b_miso, b_swap;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_wr   = act_wr.size();
    b_re   = act_re.size();
    b_fb   = act_fb.size();
    b_miso = act_miso.size();
    b_swap = swap_cnt;
  endtask

  // SPI core behaviour: the first MISO byte is taken after CS_n falls, and each
  // following one is taken as the previous byte completes, unless it was the last.
  task automatic send_txn(input logic [7:0] b[$], input bit coincide);
    int n;
    n = b.size();
    csn_fall = 1'b1; tick(1); csn_fall = 1'b0; tick(2);
    tx_ack = 1'b1;   tick(1); tx_ack = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick(5);
      rx_data  = b[k];
      rx_stb   = 1'b1;
      tx_ack   = (k < n - 1);
      csn_rise = coincide && (k == n - 1);
      tick(1);
      rx_stb = 1'b0; tx_ack = 1'b0; csn_rise = 1'b0;
    end
    if (!(coincide && n > 0)) begin
      tick(3); csn_rise = 1'b1; tick(1); csn_rise = 1'b0;
    end
  endtask

  // Transaction-level reference: what the bus and MISO must show for a byte list.
  function automatic void build_model(input logic [7:0] b[$]);
    int n;
    logic [7:0] a;
    logic [FB_AW-1:0] fa;
    n = b.size();
    exp_wr.delete(); exp_re.delete(); exp_fb.delete(); exp_miso.delete();
    exp_swap = 0;
    exp_miso.push_back(ID);
    for (int j = 1; j < n; j++) exp_miso.push_back(ID);
    if (n == 0) return;
    case (b[0])
      8'h01: if (n >= 2) begin
        for (int i = 2; i < n; i++) exp_wr.push_back({b[1] + 8'(i - 2), b[i]});
      end
      8'h02: if (n >= 2) begin
        a = b[1];
        exp_re.push_back(a);
        for (int j = 1; j <= n - 3; j++) exp_re.push_back(a + 8'(j));
        for (int j = 3; j < n; j++) exp_miso[j] = mem[a + 8'(j - 3)];
      end
      8'h80: if (n >= 3) begin
        fa = {b[1][FB_AW-9:0], b[2]};
        for (int p = 0; 4 + 2 * p <= n - 1; p++)
          exp_fb.push_back({fa + FB_AW'(p), b[3 + 2 * p], b[4 + 2 * p]});
      end
      8'h04: exp_swap = 1;
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx_stb = 1'b1; rx_data = 8'h01;
    tick(2);
    rst = 1'b0; rx_stb = 1'b0;
    n_vec++;
    if ({reg_we, reg_re, fb_we, frame_swap} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 0000", {reg_we, reg_re, fb_we, frame_swap});
    end
    n_vec++;
    if (tx_data !== ID) begin
      n_err++; $display("FAIL reset_tx_data: got %h expected %h", tx_data, ID);
    end
    n_vec++;
    if ({reg_addr, reg_wdata, fb_waddr, fb_wdata} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", reg_addr, reg_wdata, fb_waddr, fb_wdata);
    end
    // Bytes with no CS_n fall must be ignored.
    mark();
    for (int k = 0; k < 3; k++) begin
      tick(4); rx_data = (k == 0) ? 8'h01 : 8'h10 + 8'(k); rx_stb = 1'b1;
      tick(1); rx_stb = 1'b0;
    end
    tick(6);
    n_vec++;
    if ((act_wr.size() - b_wr) + (act_re.size() - b_re) + (act_fb.size() - b_fb) !== 0) begin
      n_err++; $display("FAIL idle_bytes: got %0d strobes expected 0",
        (act_wr.size() - b_wr) + (act_re.size() - b_re) + (act_fb.size() - b_fb));
    end
  endtask

  task automatic test_reg_write();
    logic [7:0] q[$];
    q = '{8'h01, 8'h10, 8'hAA, 8'hBB};
    mark(); send_txn(q, 1'b0); tick(8);
    n_vec++;
    if (act_wr.size() - b_wr !== 2) begin
      n_err++; $display("FAIL regwr_count: got %0d expected 2", act_wr.size() - b_wr);
    end else begin
      n_vec++;
      if (act_wr[b_wr] !== 16'h10AA) begin
        n_err++; $display("FAIL regwr_0: got %h expected 10AA", act_wr[b_wr]);
      end
      n_vec++;
      if (act_wr[b_wr + 1] !== 16'h11BB) begin
        n_err++; $display("FAIL regwr_1: got %h expected 11BB", act_wr[b_wr + 1]);
      end
    end
    for (int j = b_miso; j < act_miso.size(); j++) begin
      n_vec++;
      if (act_miso[j] !== ID) begin
        n_err++; $display("FAIL regwr_miso[%0d]: got %h expected %h", j - b_miso, act_miso[j], ID);
      end
    end
  endtask

  task automatic test_reg_read();
    logic [7:0] q[$];
    logic [7:0] em[5];
    logic [7:0] er[3];
    em = '{8'hA5, 8'hA5, 8'hA5, 8'h5C, 8'h3D};
    er = '{8'h20, 8'h21, 8'h22};
    q = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
    mark(); send_txn(q, 1'b0); tick(8);
    n_vec++;
    if (act_miso.size() - b_miso !== 5) begin
      n_err++; $display("FAIL regrd_miso_count: got %0d expected 5", act_miso.size() - b_miso);
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_vec++;
        if (act_miso[b_miso + j] !== em[j]) begin
          n_err++; $display("FAIL regrd_miso[%0d]: got %h expected %h", j, act_miso[b_miso + j], em[j]);
        end
      end
    end
    n_vec++;
    if (act_re.size() - b_re !== 3) begin
      n_err++; $display("FAIL regrd_re_count: got %0d expected 3", act_re.size() - b_re);
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_vec++;
        if (act_re[b_re + j] !== er[j]) begin
          n_err++; $display("FAIL regrd_re[%0d]: got %h expected %h", j, act_re[b_re + j], er[j]);
        end
      end
    end
    n_vec++;
    if (tx_data !== ID) begin
      n_err++; $display("FAIL regrd_tx_after: got %h expected %h", tx_data, ID);
    end
  endtask

  task automatic test_fb_write();
    logic [7:0] q[$];
    // Start at 0x1FF: the second pixel lands at 0x200 (carry into the high bits).
    q = '{8'h80, 8'h01, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    mark(); send_txn(q, 1'b0); tick(8);
    n_vec++;
    if (act_fb.size() - b_fb !== 2) begin
      n_err++; $display("FAIL fb_count: got %0d expected 2", act_fb.size() - b_fb);
    end else begin
      n_vec++;
      if (act_fb[b_fb] !== {13'h01FF, 16'h1234}) begin
        n_err++; $display("FAIL fb_0: got %h expected %h", act_fb[b_fb], {13'h01FF, 16'h1234});
      end
      n_vec++;
      if (act_fb[b_fb + 1] !== {13'h0200, 16'h5678}) begin
        n_err++; $display("FAIL fb_1: got %h expected %h", act_fb[b_fb + 1], {13'h0200, 16'h5678});
      end
    end
    // Top of the 13-bit space wraps to zero.
    q = '{8'h80, 8'hFF, 8'hFF, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    mark(); send_txn(q, 1'b0); tick(8);
    n_vec++;
    if (act_fb.size() - b_fb !== 2) begin
      n_err++; $display("FAIL fbwrap_count: got %0d expected 2", act_fb.size() - b_fb);
    end else begin
      n_vec++;
      if (act_fb[b_fb] !== {13'h1FFF, 16'hDEAD}) begin
        n_err++; $display("FAIL fbwrap_0: got %h expected %h", act_fb[b_fb], {13'h1FFF, 16'hDEAD});
      end
      n_vec++;
      if (act_fb[b_fb + 1] !== {13'h0000, 16'hBEEF}) begin
        n_err++; $display("FAIL fbwrap_1: got %h expected %h", act_fb[b_fb + 1], {13'h0000, 16'hBEEF});
      end
    end
  endtask

  task automatic test_swap_unknown();
    logic [7:0] q[$];
    q = '{8'h04, 8'h00};
    mark(); send_txn(q, 1'b0);
    n_vec++;
    if (frame_swap !== 1'b1) begin
      n_err++; $display("FAIL swap_pulse: got %b expected 1", frame_swap);
    end
    tick(1);
    n_vec++;
    if (frame_swap !== 1'b0) begin
      n_err++; $display("FAIL swap_width: got %b expected 0", frame_swap);
    end
    tick(6);
    n_vec++;
    if (swap_cnt - b_swap !== 1) begin
      n_err++; $display("FAIL swap_count: got %0d expected 1", swap_cnt - b_swap);
    end
    q = '{8'h33, 8'h01, 8'h02};
    mark(); send_txn(q, 1'b0); tick(8);
    n_vec++;
    if ((act_wr.size() - b_wr) + (act_re.size() - b_re) + (act_fb.size() - b_fb) + (swap_cnt - b_swap) !== 0) begin
      n_err++; $display("FAIL unknown_cmd: got %0d strobes expected 0",
        (act_wr.size() - b_wr) + (act_re.size() - b_re) + (act_fb.size() - b_fb) + (swap_cnt - b_swap));
    end
  endtask

  task automatic test_abort();
    logic [7:0] q[$];
    mark();
    q = '{8'h01, 8'h10};
    send_txn(q, 1'b0); tick(4);
    // Final data byte arrives together with CS_n rising.
    q = '{8'h01, 8'h40, 8'h77};
    send_txn(q, 1'b1); tick(8);
    n_vec++;
    if (act_wr.size() - b_wr !== 1) begin
      n_err++; $display("FAIL abort_count: got %0d expected 1", act_wr.size() - b_wr);
    end else begin
      n_vec++;
      if (act_wr[b_wr] !== 16'h4077) begin
        n_err++; $display("FAIL abort_wr: got %h expected 4077", act_wr[b_wr]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int n;
    bit co;
    for (int t = 0; t < 40; t++) begin
      q.delete();
      n = $urandom_range(0, 8);
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      if (n > 0) begin
        case ($urandom_range(0, 4))
          0: q[0] = 8'h01;
          1: q[0] = 8'h02;
          2: q[0] = 8'h80;
          3: q[0] = 8'h04;
          default: ;
        endcase
      end
      co = 1'($urandom);
      build_model(q);
      mark(); send_txn(q, co); tick(8);
      n_vec++;
      if (act_wr.size() - b_wr !== exp_wr.size()) begin
        n_err++; $display("FAIL rnd%0d_wr_count: got %0d expected %0d", t, act_wr.size() - b_wr, exp_wr.size());
      end else begin
        for (int j = 0; j < exp_wr.size(); j++) begin
          n_vec++;
          if (act_wr[b_wr + j] !== exp_wr[j]) begin
            n_err++; $display("FAIL rnd%0d_wr[%0d]: got %h expected %h", t, j, act_wr[b_wr + j], exp_wr[j]);
          end
        end
      end
      n_vec++;
      if (act_re.size() - b_re !== exp_re.size()) begin
        n_err++; $display("FAIL rnd%0d_re_count: got %0d expected %0d", t, act_re.size() - b_re, exp_re.size());
      end else begin
        for (int j = 0; j < exp_re.size(); j++) begin
          n_vec++;
          if (act_re[b_re + j] !== exp_re[j]) begin
            n_err++; $display("FAIL rnd%0d_re[%0d]: got %h expected %h", t, j, act_re[b_re + j], exp_re[j]);
          end
        end
      end
      n_vec++;
      if (act_fb.size() - b_fb !== exp_fb.size()) begin
        n_err++; $display("FAIL rnd%0d_fb_count: got %0d expected %0d", t, act_fb.size() - b_fb, exp_fb.size());
      end else begin
        for (int j = 0; j < exp_fb.size(); j++) begin
          n_vec++;
          if (act_fb[b_fb + j] !== exp_fb[j]) begin
            n_err++; $display("FAIL rnd%0d_fb[%0d]: got %h expected %h", t, j, act_fb[b_fb + j], exp_fb[j]);
          end
        end
      end
      n_vec++;
      if (act_miso.size() - b_miso !== exp_miso.size()) begin
        n_err++; $display("FAIL rnd%0d_miso_count: got %0d expected %0d", t, act_miso.size() - b_miso, exp_miso.size());
      end else begin
        for (int j = 0; j < exp_miso.size(); j++) begin
          n_vec++;
          if (act_miso[b_miso + j] !== exp_miso[j]) begin
            n_err++; $display("FAIL rnd%0d_miso[%0d]: got %h expected %h", t, j, act_miso[b_miso + j], exp_miso[j]);
          end
        end
      end
      n_vec++;
      if (swap_cnt - b_swap !== exp_swap) begin
        n_err++; $display("FAIL rnd%0d_swap: got %0d expected %0d", t, swap_cnt - b_swap, exp_swap);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h5C;
    mem[8'h21] = 8'h3D;
    test_reset();
    test_reg_write();
    test_reg_read();
    test_fb_write();
    test_swap_unknown();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
